// File: rtl/tt_sweep_capture.sv
// tt_sweep_capture: exhaustive 7-input truth-table sweep around one cell.
// Drives x = 0..127, captures the cell output into a 128-bit table,
// compares it against EXP_TT and then streams the table as four 32-bit words.
module tt_sweep_capture #(
   parameter logic [127:0] EXP_TT  = 128'heaeaeae8eae8e8a8eae8e8a8e8a8a8a8,
   parameter int           DUT_LAT = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   output logic [6:0]   x,
   input  logic         f_in,
   output logic         busy,
   output logic         done,
   output logic [127:0] tt,
   output logic         match,
   output logic [7:0]   mismatch_cnt,
   output logic         first_err_vld,
   output logic [6:0]   first_err_idx,
   output logic         tt_word_valid,
   input  logic         tt_word_ready,
   output logic [31:0]  tt_word
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SWEEP = 3'd1,
      S_DRAIN = 3'd2,
      S_EMIT  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t         r_state;
   state_t         w_state_nxt;
   logic [6:0]     r_x;
   logic [127:0]   r_tt;
   logic           r_match;
   logic [7:0]     r_mismatch_cnt;
   logic           r_first_err_vld;
   logic [6:0]     r_first_err_idx;
   logic [1:0]     r_k;

   logic           w_cap_vld;
   logic [6:0]     w_cap_idx;
   logic           w_last_cap;
   logic           w_miss;
   logic [7:0]     w_cnt_nxt;
   logic           w_start_ok;
   logic           w_xfer;

   // Index delay line: pairs each f_in sample with the vector that produced it.
   generate
      if (DUT_LAT == 0) begin : g_lat0
         assign w_cap_vld = (r_state == S_SWEEP);
         assign w_cap_idx = r_x;
      end else begin : g_latn
         logic [DUT_LAT:1]      r_vld_pipe;
         logic [DUT_LAT:1][6:0] r_idx_pipe;

         // Shift the vector index and its valid bit alongside the cell latency.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_vld_pipe <= '0;
               r_idx_pipe <= '0;
            end else begin
               r_vld_pipe[1] <= (r_state == S_SWEEP);
               r_idx_pipe[1] <= r_x;
               for (int i = 2; i <= DUT_LAT; i++) begin
                  r_vld_pipe[i] <= r_vld_pipe[i-1];
                  r_idx_pipe[i] <= r_idx_pipe[i-1];
               end
            end
         end

         assign w_cap_vld = r_vld_pipe[DUT_LAT];
         assign w_cap_idx = r_idx_pipe[DUT_LAT];
      end
   endgenerate

   assign w_last_cap = w_cap_vld && (w_cap_idx == 7'd127);
   assign w_miss     = w_cap_vld && (f_in != EXP_TT[w_cap_idx]);
   assign w_cnt_nxt  = r_mismatch_cnt + {7'd0, w_miss};
   assign w_start_ok = (r_state == S_IDLE) && start;
   assign w_xfer     = (r_state == S_EMIT) && tt_word_ready;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state logic; the sweep skips DRAIN when the last sample is already in.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_SWEEP;
         S_SWEEP: if (r_x == 7'd127) w_state_nxt = w_last_cap ? S_EMIT : S_DRAIN;
         S_DRAIN: if (w_last_cap) w_state_nxt = S_EMIT;
         S_EMIT:  if (tt_word_ready && (r_k == 2'd3)) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Sweep counter, capture/compare datapath and output word counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_x             <= '0;
         r_tt            <= '0;
         r_match         <= 1'b0;
         r_mismatch_cnt  <= '0;
         r_first_err_vld <= 1'b0;
         r_first_err_idx <= '0;
         r_k             <= '0;
      end else begin
         if (w_start_ok) begin
            r_x             <= '0;
            r_tt            <= '0;
            r_match         <= 1'b0;
            r_mismatch_cnt  <= '0;
            r_first_err_vld <= 1'b0;
            r_first_err_idx <= '0;
            r_k             <= '0;
         end
         // 7-bit counter wraps 127 -> 0 exactly as the sweep ends.
         if (r_state == S_SWEEP) r_x <= r_x + 7'd1;
         if (w_cap_vld) begin
            r_tt[w_cap_idx] <= f_in;
            r_mismatch_cnt  <= w_cnt_nxt;
            // Indices arrive in ascending order, so the first miss is the lowest.
            if (w_miss && !r_first_err_vld) begin
               r_first_err_vld <= 1'b1;
               r_first_err_idx <= w_cap_idx;
            end
            if (w_last_cap) r_match <= (w_cnt_nxt == 8'd0);
         end
         if (w_xfer) r_k <= r_k + 2'd1;
      end
   end

   assign x             = r_x;
   assign busy          = (r_state != S_IDLE);
   assign done          = (r_state == S_DONE);
   assign tt            = r_tt;
   assign match         = r_match;
   assign mismatch_cnt  = r_mismatch_cnt;
   assign first_err_vld = r_first_err_vld;
   assign first_err_idx = r_first_err_idx;
   assign tt_word_valid = (r_state == S_EMIT);
   assign tt_word       = r_tt[{r_k, 5'd0} +: 32];

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Scoreboard bench for tt_sweep_capture: stimulus pushes expected words and
// final results; a negedge monitor pops and compares as the DUT presents them.
module tb_tt_sweep_capture;

   localparam logic [127:0] EXP = 128'heaeaeae8eae8e8a8eae8e8a8e8a8a8a8;

   typedef struct {
      logic [127:0] tt;
      logic         match;
      logic [7:0]   cnt;
      logic         fev;
      logic [6:0]   fei;
      int           lat;
   } res_t;

   logic clk = 1'b0;
   logic rst, st, ready, zero_mode, sel;
   logic [127:0] tbl;
   int cyc = 0;
   int start_cyc = 0;
   int total = 0;
   int pass = 0;
   logic prev_stall = 1'b0;
   res_t res_q[$];
   logic [31:0] word_q[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // DUT 0: combinational cell (DUT_LAT=0)
   logic [6:0] x0, fei0;
   logic f0, busy0, done0, match0, fev0, val0;
   logic [127:0] tt0;
   logic [7:0] cnt0;
   logic [31:0] word0;
   assign f0 = zero_mode ? 1'b0 : tbl[x0];

   tt_sweep_capture #(.EXP_TT(EXP), .DUT_LAT(0)) dut0 (
      .clk(clk), .rst(rst), .start(st & ~sel), .x(x0), .f_in(f0),
      .busy(busy0), .done(done0), .tt(tt0), .match(match0),
      .mismatch_cnt(cnt0), .first_err_vld(fev0), .first_err_idx(fei0),
      .tt_word_valid(val0), .tt_word_ready(ready), .tt_word(word0));

   // DUT 2: cell with two register stages (DUT_LAT=2)
   logic [6:0] x2, fei2;
   logic c1, c2, busy2, done2, match2, fev2, val2;
   logic [127:0] tt2;
   logic [7:0] cnt2;
   logic [31:0] word2;
   always @(posedge clk) begin
      c1 <= tbl[x2];
      c2 <= c1;
   end

   tt_sweep_capture #(.EXP_TT(EXP), .DUT_LAT(2)) dut2 (
      .clk(clk), .rst(rst), .start(st & sel), .x(x2), .f_in(c2),
      .busy(busy2), .done(done2), .tt(tt2), .match(match2),
      .mismatch_cnt(cnt2), .first_err_vld(fev2), .first_err_idx(fei2),
      .tt_word_valid(val2), .tt_word_ready(ready), .tt_word(word2));

   // Monitored view of whichever instance is under test.
   wire        m_busy  = sel ? busy2  : busy0;
   wire        m_done  = sel ? done2  : done0;
   wire        m_match = sel ? match2 : match0;
   wire        m_fev   = sel ? fev2   : fev0;
   wire        m_val   = sel ? val2   : val0;
   wire [6:0]  m_x     = sel ? x2     : x0;
   wire [6:0]  m_fei   = sel ? fei2   : fei0;
   wire [7:0]  m_cnt   = sel ? cnt2   : cnt0;
   wire [127:0] m_tt   = sel ? tt2    : tt0;
   wire [31:0] m_word  = sel ? word2  : word0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act === exp) pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic fail(input string nm);
      total++;
      $display("FAIL %s: got unexpected event expected none", nm);
   endtask

   // Monitor: compare every transferred word, stall hold and done-time results.
   always @(negedge clk) begin
      if (!rst) begin
         if (prev_stall) chk("valid_hold", 128'(m_val), 128'(1'b1));
         if (m_val && !ready && word_q.size() > 0)
            chk("word_hold", 128'(m_word), 128'(word_q[0]));
         if (m_val && ready) begin
            if (word_q.size() == 0) fail("unexpected_word");
            else chk("word", 128'(m_word), 128'(word_q.pop_front()));
         end
         if (m_done) begin
            if (res_q.size() == 0) fail("unexpected_done");
            else begin
               res_t r;
               r = res_q.pop_front();
               chk("tt", m_tt, r.tt);
               chk("match", 128'(m_match), 128'(r.match));
               chk("mismatch_cnt", 128'(m_cnt), 128'(r.cnt));
               chk("first_err_vld", 128'(m_fev), 128'(r.fev));
               chk("first_err_idx", 128'(m_fei), 128'(r.fei));
               chk("done_latency", 128'(cyc - start_cyc), 128'(r.lat));
            end
         end
      end
      prev_stall <= !rst && m_val && !ready;
   end

   task automatic zero_checks(input string tag);
      chk({tag, "_busy"}, 128'(m_busy), 128'(1'b0));
      chk({tag, "_done"}, 128'(m_done), 128'(1'b0));
      chk({tag, "_x"}, 128'(m_x), 128'(7'd0));
      chk({tag, "_tt"}, m_tt, 128'd0);
      chk({tag, "_match"}, 128'(m_match), 128'(1'b0));
      chk({tag, "_cnt"}, 128'(m_cnt), 128'(8'd0));
      chk({tag, "_fev"}, 128'(m_fev), 128'(1'b0));
      chk({tag, "_fei"}, 128'(m_fei), 128'(7'd0));
      chk({tag, "_valid"}, 128'(m_val), 128'(1'b0));
   endtask

   // One complete sweep with its expected results queued up front.
   task automatic run(input logic use2, input logic zero, input logic [127:0] ett,
                      input logic m, input logic [7:0] c, input logic fv,
                      input logic [6:0] fi, input int lat, input logic stall,
                      input logic hold_start);
      res_t r;
      int n;
      logic [127:0] t;
      sel = use2;
      zero_mode = zero;
      t = ett;
      for (int k = 0; k < 4; k++) word_q.push_back(t[32*k +: 32]);
      r.tt = ett; r.match = m; r.cnt = c; r.fev = fv; r.fei = fi; r.lat = lat;
      res_q.push_back(r);
      @(posedge clk); #1;
      st = 1'b1;
      start_cyc = cyc;
      @(posedge clk); #1;
      if (!hold_start) st = 1'b0;
      n = 0;
      while (res_q.size() != 0 && n < 400) begin
         if (hold_start && cyc == start_cyc + 100) st = 1'b0;
         if (stall && cyc == start_cyc + 130) ready = 1'b0;
         if (stall && cyc == start_cyc + 140) ready = 1'b1;
         @(posedge clk); #1;
         n++;
      end
      if (n >= 400) fail("done_timeout");
      st = 1'b0;
      ready = 1'b1;
      res_q.delete();
      word_q.delete();
      repeat (2) @(posedge clk);
   endtask

   initial begin
      int n;
      rst = 1'b1; st = 1'b0; ready = 1'b1; zero_mode = 1'b0; sel = 1'b0;
      tbl = EXP;
      repeat (3) @(posedge clk);
      #1;
      zero_checks("reset");
      rst = 1'b0;

      // T1: correct cell, no latency
      run(1'b0, 1'b0, EXP, 1'b1, 8'd0, 1'b0, 7'd0, 133, 1'b0, 1'b0);
      // T2: output stuck at 0
      run(1'b0, 1'b1, 128'd0, 1'b0, 8'd64, 1'b1, 7'd3, 133, 1'b0, 1'b0);
      // T3: backpressure on word 1
      run(1'b0, 1'b0, EXP, 1'b1, 8'd0, 1'b0, 7'd0, 143, 1'b1, 1'b0);
      // T4: two-stage registered cell
      run(1'b1, 1'b0, EXP, 1'b1, 8'd0, 1'b0, 7'd0, 135, 1'b0, 1'b0);

      // T5: reset in the middle of a sweep
      sel = 1'b0; zero_mode = 1'b0;
      @(posedge clk); #1;
      st = 1'b1;
      @(posedge clk); #1;
      st = 1'b0;
      n = 0;
      while (x0 != 7'd60 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 200) fail("x60_timeout");
      #2 rst = 1'b1;
      #1 zero_checks("midreset");
      @(posedge clk); #1;
      rst = 1'b0;
      run(1'b0, 1'b0, EXP, 1'b1, 8'd0, 1'b0, 7'd0, 133, 1'b0, 1'b0);

      // T6: start held high during the sweep
      run(1'b0, 1'b0, EXP, 1'b1, 8'd0, 1'b0, 7'd0, 133, 1'b0, 1'b1);

      repeat (5) @(posedge clk);
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end

endmodule
